// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose
//   Shares one single-port memory between an instruction-fetch port (read
//   only) and a data-memory port (read/write). One transaction is in flight
//   at a time. When both ports ask in the same idle cycle, the grant
//   alternates (round-robin) starting with the data port after reset.
//   Each completed transaction produces a one-cycle done pulse on the
//   owning port, and read data is latched into that port's rdata register.
//
// Optional feature
//   ARB_TIMEOUT_EN : when defined, a watchdog abandons a transaction whose
//                    mem_ack has not arrived after TIMEOUT busy cycles, and
//                    reports it with err alongside the done pulse. When
//                    undefined, err is tied low and the arbiter waits for
//                    mem_ack indefinitely.
//
// Parameters
//   ADDR_W   memory address width
//   DATA_W   memory data width
//   TIMEOUT  watchdog limit in cycles (only meaningful with ARB_TIMEOUT_EN)
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   if_req     in   instruction-fetch request
//   if_addr    in   instruction-fetch address
//   if_rdata   out  instruction-fetch read data (held until next IF read)
//   if_done    out  one-cycle completion pulse for the fetch port
//   dm_req     in   data-memory request
//   dm_we      in   data-memory write enable
//   dm_addr    in   data-memory address
//   dm_wdata   in   data-memory write data
//   dm_rdata   out  data-memory read data (held until next DM read)
//   dm_done    out  one-cycle completion pulse for the data port
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ack
//   mem_ack    in   memory acknowledge
//   err        out  high with a done pulse when the transaction timed out
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  // last_grant encoding
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                if_done_q,   if_done_d;
  logic                dm_done_q,   dm_done_d;
  logic                last_grant_q, last_grant_d;

  logic if_valid;
  logic dm_valid;
  logic grant_if;
  logic grant_dm;
  logic busy;
  logic timeout_fire;

  // A request seen while its own done pulse is high belongs to the
  // transaction that just finished, so it must not be granted again.
  assign if_valid = if_req & ~if_done_q;
  assign dm_valid = dm_req & ~dm_done_q;
  assign busy     = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Grant decision (only evaluated in IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE) begin
      if (if_valid && dm_valid) begin
        // Contention: favour whichever port did not win last time.
        if (last_grant_q == GRANT_IF) begin
          grant_dm = 1'b1;
        end else begin
          grant_if = 1'b1;
        end
      end else if (if_valid) begin
        grant_if = 1'b1;
      end else if (dm_valid) begin
        grant_dm = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        // mem_ack arriving here is stale or spurious and is ignored.
        if (grant_if) begin
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          last_grant_d = GRANT_IF;
        end else if (grant_dm) begin
          state_d      = BUSY_DM;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we;
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          last_grant_d = GRANT_DM;
        end
      end

      BUSY_IF: begin
        // mem_ack is checked first so an ack on the timeout edge completes
        // the transaction normally.
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end else if (timeout_fire) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = '0;
        end
      end

      BUSY_DM: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          dm_done_d = 1'b1;
          // Writes leave the previously read value in place.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (timeout_fire) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_done_d  = 1'b1;
          dm_rdata_d = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      // Pretending IF won last means the first contention goes to DM.
      last_grant_q <= GRANT_IF;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q,      err_d;

  // The counter has already reached TIMEOUT on earlier unacknowledged
  // cycles; this edge is the one that gives up.
  assign timeout_fire = busy && !mem_ack && (wait_cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_if || grant_dm) begin
      wait_cnt_d = '0;
    end else if (busy && !mem_ack && !timeout_fire) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    err_d = timeout_fire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog TIMEOUT has no effect.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_fire   = 1'b0;
  assign err            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed, table-driven bench for mem_port_arbiter. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point, i.e.
// after the edge has updated the DUT registers. The bench plays the role of
// the memory by driving mem_ack/mem_rdata directly.
// Build with or without ARB_TIMEOUT_EN; the watchdog sequence matching the
// build is selected automatically.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          e_mem_req;
    logic          e_mem_we;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata;
    logic          e_if_done;
    logic          e_dm_done;
    logic [DW-1:0] e_if_rdata;
    logic [DW-1:0] e_dm_rdata;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic ir, input logic [AW-1:0] ia,
    input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
    input logic ak, input logic [DW-1:0] rd,
    input logic emr, input logic emw, input logic [AW-1:0] ema, input logic [DW-1:0] emd,
    input logic eid, input logic edd, input logic [DW-1:0] eir, input logic [DW-1:0] edr);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;
    v.dm_req = dr;  v.dm_we = dw;  v.dm_addr = da;  v.dm_wdata = dd;
    v.mem_ack = ak; v.mem_rdata = rd;
    v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema; v.e_mem_wdata = emd;
    v.e_if_done = eid; v.e_dm_done = edd; v.e_if_rdata = eir; v.e_dm_rdata = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  int done_seen;
  int bad;

  initial begin
    // Cycle-by-cycle script; expected values are the register state right
    // after the edge that consumed the row's inputs.
    //            if_req  if_addr        dm dw dm_addr        dm_wdata       ack rdata         | mreq we mem_addr     mem_wdata      ifd dmd if_rdata       dm_rdata
    // zero-wait IF read
    vecs[0]  = mk(1, 32'h00000040, 0, 0, 32'h0,        32'h0,         0, 32'h0,         1, 0, 32'h00000040, 32'h0,         0, 0, 32'h0,         32'h0);
    vecs[1]  = mk(1, 32'h00000040, 0, 0, 32'h0,        32'h0,         1, 32'h8C220004,  0, 0, 32'h00000040, 32'h0,         1, 0, 32'h8C220004,  32'h0);
    vecs[2]  = mk(0, 32'h00000040, 0, 0, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h00000040, 32'h0,         0, 0, 32'h8C220004,  32'h0);
    // DM write, three wait states then ack (rdata on ack must be ignored)
    vecs[3]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'hDEADBEEF,  0, 32'h0,         1, 1, 32'h00000010, 32'hDEADBEEF,  0, 0, 32'h8C220004,  32'h0);
    vecs[4]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'hDEADBEEF,  0, 32'h0,         1, 1, 32'h00000010, 32'hDEADBEEF,  0, 0, 32'h8C220004,  32'h0);
    vecs[5]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'hDEADBEEF,  0, 32'h0,         1, 1, 32'h00000010, 32'hDEADBEEF,  0, 0, 32'h8C220004,  32'h0);
    vecs[6]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'hDEADBEEF,  0, 32'h0,         1, 1, 32'h00000010, 32'hDEADBEEF,  0, 0, 32'h8C220004,  32'h0);
    vecs[7]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'hDEADBEEF,  1, 32'h12345678,  0, 0, 32'h00000010, 32'hDEADBEEF,  0, 1, 32'h8C220004,  32'h0);
    // new DM read presented in the done cycle: ignored there, granted next
    vecs[8]  = mk(0, 32'h0,        1, 0, 32'h00000020, 32'h0,         0, 32'h0,         0, 0, 32'h00000010, 32'hDEADBEEF,  0, 0, 32'h8C220004,  32'h0);
    vecs[9]  = mk(0, 32'h0,        1, 0, 32'h00000020, 32'h0,         0, 32'h0,         1, 0, 32'h00000020, 32'h0,         0, 0, 32'h8C220004,  32'h0);
    vecs[10] = mk(0, 32'h0,        1, 0, 32'h00000020, 32'h0,         1, 32'hCAFEF00D,  0, 0, 32'h00000020, 32'h0,         0, 1, 32'h8C220004,  32'hCAFEF00D);
    vecs[11] = mk(0, 32'h0,        0, 0, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h00000020, 32'h0,         0, 0, 32'h8C220004,  32'hCAFEF00D);
    // contention after a DM grant: IF wins, then DM, then IF again
    vecs[12] = mk(1, 32'h00000100, 1, 0, 32'h00000200, 32'h0,         0, 32'h0,         1, 0, 32'h00000100, 32'h0,         0, 0, 32'h8C220004,  32'hCAFEF00D);
    vecs[13] = mk(1, 32'h00000100, 1, 0, 32'h00000200, 32'h0,         1, 32'h11111111,  0, 0, 32'h00000100, 32'h0,         1, 0, 32'h11111111,  32'hCAFEF00D);
    vecs[14] = mk(1, 32'h00000104, 1, 0, 32'h00000200, 32'h0,         0, 32'h0,         1, 0, 32'h00000200, 32'h0,         0, 0, 32'h11111111,  32'hCAFEF00D);
    vecs[15] = mk(1, 32'h00000104, 1, 0, 32'h00000200, 32'h0,         1, 32'h22222222,  0, 0, 32'h00000200, 32'h0,         0, 1, 32'h11111111,  32'h22222222);
    vecs[16] = mk(1, 32'h00000104, 0, 0, 32'h0,        32'h0,         0, 32'h0,         1, 0, 32'h00000104, 32'h0,         0, 0, 32'h11111111,  32'h22222222);
    vecs[17] = mk(1, 32'h00000104, 0, 0, 32'h0,        32'h0,         1, 32'h33333333,  0, 0, 32'h00000104, 32'h0,         1, 0, 32'h33333333,  32'h22222222);
    vecs[18] = mk(0, 32'h0,        0, 0, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h00000104, 32'h0,         0, 0, 32'h33333333,  32'h22222222);
    // ack while idle is ignored
    vecs[19] = mk(0, 32'h0,        0, 0, 32'h0,        32'h0,         1, 32'h44444444,  0, 0, 32'h00000104, 32'h0,         0, 0, 32'h33333333,  32'h22222222);
    vecs[20] = mk(0, 32'h0,        0, 0, 32'h0,        32'h0,         0, 32'h0,         0, 0, 32'h00000104, 32'h0,         0, 0, 32'h33333333,  32'h22222222);

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",   {31'b0, mem_req}, 32'h0);
    check("rst_mem_we",    {31'b0, mem_we},  32'h0);
    check("rst_mem_addr",  mem_addr,         32'h0);
    check("rst_mem_wdata", mem_wdata,        32'h0);
    check("rst_if_done",   {31'b0, if_done}, 32'h0);
    check("rst_dm_done",   {31'b0, dm_done}, 32'h0);
    check("rst_if_rdata",  if_rdata,         32'h0);
    check("rst_dm_rdata",  dm_rdata,         32'h0);
    check("rst_err",       {31'b0, err},     32'h0);
    $display("reset: mem_req=%0b if_done=%0b dm_done=%0b err=%0b", mem_req, if_done, dm_done, err);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      dm_req    = vecs[i].dm_req;
      dm_we     = vecs[i].dm_we;
      dm_addr   = vecs[i].dm_addr;
      dm_wdata  = vecs[i].dm_wdata;
      mem_ack   = vecs[i].mem_ack;
      mem_rdata = vecs[i].mem_rdata;
      tick();
      $display("vec %0d: mem_req=%0b mem_we=%0b mem_addr=%h if_done=%0b dm_done=%0b if_rdata=%h dm_rdata=%h",
               i, mem_req, mem_we, mem_addr, if_done, dm_done, if_rdata, dm_rdata);
      check($sformatf("v%0d_mem_req", i),   {31'b0, mem_req}, {31'b0, vecs[i].e_mem_req});
      check($sformatf("v%0d_mem_we", i),    {31'b0, mem_we},  {31'b0, vecs[i].e_mem_we});
      check($sformatf("v%0d_mem_addr", i),  mem_addr,         vecs[i].e_mem_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata,        vecs[i].e_mem_wdata);
      check($sformatf("v%0d_if_done", i),   {31'b0, if_done}, {31'b0, vecs[i].e_if_done});
      check($sformatf("v%0d_dm_done", i),   {31'b0, dm_done}, {31'b0, vecs[i].e_dm_done});
      check($sformatf("v%0d_if_rdata", i),  if_rdata,         vecs[i].e_if_rdata);
      check($sformatf("v%0d_dm_rdata", i),  dm_rdata,         vecs[i].e_dm_rdata);
      check($sformatf("v%0d_err", i),       {31'b0, err},     32'h0);
    end

    // ---------------- contention from reset, zero-wait memory ----------------
    // Dones expected at cycles 2,4,6,8 in the order DM, IF, DM, IF.
    rst = 1'b0;
    idle_inputs();
    if_req  = 1'b1;
    if_addr = 32'h000000A0;
    dm_req  = 1'b1;
    dm_addr = 32'h000000B0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      $display("rr cycle %0d: mem_req=%0b mem_addr=%h if_done=%0b dm_done=%0b", c, mem_req, mem_addr, if_done, dm_done);
      check($sformatf("rr%0d_if_done", c), {31'b0, if_done}, {31'b0, (c == 4 || c == 8)});
      check($sformatf("rr%0d_dm_done", c), {31'b0, dm_done}, {31'b0, (c == 2 || c == 6)});
      if (c == 2) check("rr_dm_rdata", dm_rdata, 32'h5A5A00B0);
      if (c == 4) check("rr_if_rdata", if_rdata, 32'h5A5A00A0);
      mem_ack   = mem_req;
      mem_rdata = mem_addr ^ 32'h5A5A0000;
    end

    // ---------------- reset during BUSY_DM ----------------
    idle_inputs();
    repeat (2) tick();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h00000030;
    dm_wdata = 32'h00000055;
    tick();
    check("rstmid_busy_mem_req", {31'b0, mem_req}, 32'h1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    $display("rstmid: mem_req=%0b mem_we=%0b mem_addr=%h dm_rdata=%h", mem_req, mem_we, mem_addr, dm_rdata);
    check("rstmid_mem_req",  {31'b0, mem_req}, 32'h0);
    check("rstmid_mem_we",   {31'b0, mem_we},  32'h0);
    check("rstmid_mem_addr", mem_addr,         32'h0);
    check("rstmid_dm_rdata", dm_rdata,         32'h0);
    check("rstmid_if_rdata", if_rdata,         32'h0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      done_seen += int'(if_done) + int'(dm_done) + int'(mem_req);
    end
    check("rstmid_late_ack_no_done", done_seen, 32'h0);
    idle_inputs();
    tick();

`ifdef ARB_TIMEOUT_EN
    // ---------------- watchdog, TIMEOUT=4 ----------------
    // Seed if_rdata with a non-zero value so the clear on timeout is visible.
    if_req  = 1'b1;
    if_addr = 32'h00000080;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000099;
    tick();
    check("to_seed_if_rdata", if_rdata, 32'h00000099);
    idle_inputs();
    tick();
    if_req  = 1'b1;
    if_addr = 32'h00000400;
    tick();
    check("to_mem_req_rise", {31'b0, mem_req}, 32'h1);
    bad = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (if_done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b1) bad++;
    end
    check("to_wait_phase", bad, 32'h0);
    tick();
    $display("timeout: if_done=%0b err=%0b if_rdata=%h mem_req=%0b", if_done, err, if_rdata, mem_req);
    check("to_if_done", {31'b0, if_done}, 32'h1);
    check("to_err",     {31'b0, err},     32'h1);
    check("to_if_rdata", if_rdata,        32'h0);
    check("to_mem_req", {31'b0, mem_req}, 32'h0);
    if_req = 1'b0;
    tick();
    check("to_err_drop",  {31'b0, err},     32'h0);
    check("to_done_drop", {31'b0, if_done}, 32'h0);
    // ack on the timeout edge: normal completion
    if_req  = 1'b1;
    if_addr = 32'h00000404;
    tick();
    repeat (4) tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000ABC;
    tick();
    $display("ack-at-timeout: if_done=%0b err=%0b if_rdata=%h", if_done, err, if_rdata);
    check("toack_if_done", {31'b0, if_done}, 32'h1);
    check("toack_err",     {31'b0, err},     32'h0);
    check("toack_if_rdata", if_rdata,        32'h00000ABC);
    idle_inputs();
    tick();
`else
    // ---------------- no watchdog: wait 300 cycles ----------------
    if_req  = 1'b1;
    if_addr = 32'h00000300;
    tick();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (mem_req !== 1'b1 || err !== 1'b0 || if_done !== 1'b0 || mem_addr !== 32'h00000300) bad++;
    end
    check("long_wait_hold", bad, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000077;
    tick();
    $display("long wait: if_done=%0b err=%0b if_rdata=%h", if_done, err, if_rdata);
    check("long_if_done",  {31'b0, if_done}, 32'h1);
    check("long_err",      {31'b0, err},     32'h0);
    check("long_if_rdata", if_rdata,         32'h00000077);
    idle_inputs();
    tick();
    check("long_done_drop", {31'b0, if_done}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT, default 255, max cycles awaiting mem_ack (used only under REQ-029).
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Ports if_req in 1, if_addr in ADDR_W: instruction-fetch request (read-only) and address.
REQ-007 Ports if_rdata out DATA_W, if_done out 1: fetch read data and one-cycle completion pulse.
REQ-008 Ports dm_req in 1, dm_we in 1, dm_addr in ADDR_W, dm_wdata in DATA_W: data-memory request, write enable, address, write data.
REQ-009 Ports dm_rdata out DATA_W, dm_done out 1: data read data and one-cycle completion pulse.
REQ-010 Ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W: shared single-port memory request.
REQ-011 Ports mem_rdata in DATA_W, mem_ack in 1: memory read data, valid when mem_ack high.
REQ-012 Port err  out 1  high with a done pulse when the transaction timed out.

Function
REQ-013 FSM states: IDLE, BUSY_IF, BUSY_DM; encoding free.
REQ-014 Requesters hold req/addr/we/wdata stable from assertion until the cycle their done is seen high, then drop req or issue a new request.
REQ-015 IDLE, only if_req (valid): next state BUSY_IF; mem_addr<=if_addr, mem_we<=0, mem_wdata<=0, mem_req<=1.
REQ-016 IDLE, only dm_req (valid): next state BUSY_DM; mem_addr<=dm_addr, mem_we<=dm_we, mem_wdata<=dm_wdata, mem_req<=1.
REQ-017 IDLE, both valid: round-robin; grant requester not granted last; last_grant updates on every grant.
REQ-018 A req is invalid (ignored) in the cycle its own done is high, preventing double service of one request.
REQ-019 BUSY_x: mem_req and mem_* held constant until mem_ack sampled high.
REQ-020 On mem_ack in BUSY_x: next cycle x_done=1 for exactly one cycle, x_rdata<=mem_rdata (reads) or unchanged (writes), mem_req<=0, mem_we<=0, state IDLE.
REQ-021 x_rdata holds its value until the next completed read of requester x.
REQ-022 mem_ack sampled in IDLE is ignored; no done, no state change.
REQ-023 Zero-wait memory (ack in first mem_req cycle): req-to-done latency 2 cycles; back-to-back throughput one transaction per 3 cycles.
REQ-024 if_done and dm_done never high in the same cycle; mem_req never high in IDLE.

Reset
REQ-025 rst low asynchronously forces: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, dm_done=0, if_rdata=0, dm_rdata=0, err=0, timeout counter 0, last_grant=IF (first contention goes to DM).
REQ-026 Reset mid-transaction abandons it: no done pulse is issued after release for that transaction.
REQ-027 First arbitration occurs on the first rising edge with rst high.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN selects the watchdog.
REQ-029 Defined: counter clears on entry to BUSY_x, increments each BUSY cycle without mem_ack; on reaching TIMEOUT, next cycle mem_req=0, x_done=1, err=1 (one cycle), x_rdata=0, state IDLE; mem_ack on the same edge as timeout wins (normal completion, err=0).
REQ-030 Undefined: no counter, err tied 0, BUSY_x waits indefinitely for mem_ack.

Verification
REQ-031 if_req=1, if_addr=0x00000040, mem_ack same cycle as mem_req, mem_rdata=0x8C220004 -> if_done pulses 2 cycles after if_req, if_rdata=0x8C220004, mem_we=0.
REQ-032 dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, ack after 3 wait cycles -> mem_* held stable 4 cycles, dm_done one pulse, dm_rdata unchanged.
REQ-033 if_req and dm_req both held high from reset release, zero-wait memory -> grants DM, IF, DM, IF; done pulses alternate, never coincident.
REQ-034 rst driven low while BUSY_DM with mem_req high -> mem_req=0 immediately; after release, late mem_ack=1 produces no done.
REQ-035 ARB_TIMEOUT_EN defined, TIMEOUT=4, mem_ack never asserted -> if_done=1 and err=1 5 cycles after mem_req rises, if_rdata=0, FSM returns IDLE.
REQ-036 ARB_TIMEOUT_EN undefined, mem_ack withheld 300 cycles -> mem_req stays high, err stays 0, done on eventual ack.
